// File: rtl/serie_paralelo_idl_pkg.sv
// Shared definitions for the IDL/COM serial receiver: character defaults,
// state encoding and counter widths.
package serie_paralelo_idl_pkg;

    localparam logic [7:0] COM_CHAR_DEF = 8'hBC;
    localparam logic [7:0] IDL_CHAR_DEF = 8'hFC;

    localparam int BIT_CNT_W  = 3;
    localparam int COM_CNT_W  = 4;
    localparam int LOSS_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } rx_state_e;

    // All-zeros or all-ones bytes indicate a dead or stuck line.
    function automatic logic is_loss_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/serial_rx_shift.sv
// Serial-in shift register with byte-phase counter; emits the next shift
// value and a strobe on the edge that completes an aligned byte.
module serial_rx_shift
    import serie_paralelo_idl_pkg::*;
(
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    input  logic       realign,
    input  logic       track,
    output logic [7:0] nsr,
    output logic       boundary
);

    logic [6:0]           sr;
    logic [BIT_CNT_W-1:0] bit_cnt;

    assign nsr      = {sr, data_in};
    assign boundary = track && (bit_cnt == '1);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            sr <= nsr[6:0];
            if (realign)
                bit_cnt <= '0;
            else if (track)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serie_paralelo_idl.sv
// Receive end of the serial IDL/COM link: COM hunt, lock/loss FSM, byte output.
// Optional lock-failure counter on err_cnt when RX_ERR_CNT_EN is defined.
module serie_paralelo_idl
    import serie_paralelo_idl_pkg::*;
#(
    parameter logic [7:0] COM_CHAR   = COM_CHAR_DEF,
    parameter logic [7:0] IDL_CHAR   = IDL_CHAR_DEF,
    parameter int         LOCK_COUNT = 4,
    parameter int         LOSS_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       idl_out,
    output logic       active
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [COM_CNT_W-1:0]  LOCK_LAST = COM_CNT_W'(LOCK_COUNT);
    localparam logic [LOSS_CNT_W-1:0] LOSS_LAST = LOSS_CNT_W'(LOSS_COUNT);

    rx_state_e             state_q, state_d;
    logic [COM_CNT_W-1:0]  com_q, com_d, com_inc;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d, loss_inc;
    logic [7:0]            data_d;
    logic                  valid_d, idl_d;
    logic                  realign;
    logic [7:0]            nsr;
    logic                  boundary;

    serial_rx_shift u_shift (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .realign  (realign),
        .track    (state_q != ST_SEARCH),
        .nsr      (nsr),
        .boundary (boundary)
    );

    assign com_inc  = com_q + 1'b1;
    assign loss_inc = loss_q + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches.
        state_d = state_q;
        com_d   = com_q;
        loss_d  = loss_q;
        data_d  = data_out;
        valid_d = 1'b0;
        idl_d   = 1'b0;
        realign = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                if (nsr == COM_CHAR) begin
                    realign = 1'b1;
                    com_d   = COM_CNT_W'(1);
                    state_d = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (boundary) begin
                    if (nsr == COM_CHAR) begin
                        com_d = com_inc;
                        if (com_inc == LOCK_LAST)
                            state_d = ST_ACTIVE;
                    end else begin
                        com_d   = '0;
                        state_d = ST_SEARCH;
                    end
                end
            end

            ST_ACTIVE: begin
                if (boundary) begin
                    data_d  = nsr;
                    idl_d   = (nsr == IDL_CHAR);
                    valid_d = (nsr != COM_CHAR) && (nsr != IDL_CHAR);
                    if (is_loss_byte(nsr)) begin
                        if (loss_inc == LOSS_LAST) begin
                            loss_d  = '0;
                            com_d   = '0;
                            state_d = ST_SEARCH;
                        end else begin
                            loss_d = loss_inc;
                        end
                    end else begin
                        loss_d = '0;
                    end
                end
            end

            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_SEARCH;
            com_q     <= '0;
            loss_q    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            idl_out   <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_q     <= com_d;
            loss_q    <= loss_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            idl_out   <= idl_d;
        end
    end

    assign active = (state_q == ST_ACTIVE);

`ifdef RX_ERR_CNT_EN
    // A failure is any exit from ALIGN or ACTIVE back to SEARCH.
    logic lock_fail;
    assign lock_fail = (state_q != ST_SEARCH) && (state_d == ST_SEARCH);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L)
            err_cnt <= '0;
        else if (lock_fail && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_serie_paralelo_idl.sv
// Self-checking bench for serie_paralelo_idl: directed link scenarios followed by
// random byte streams, compared every bit against a byte-level reference model.
module tb_serie_paralelo_idl;

    localparam int LOCK = 4;
    localparam int LOSS = 4;
    localparam int M_SEARCH = 0;
    localparam int M_ALIGN  = 1;
    localparam int M_LOCKED = 2;

    logic       clk_32f;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       idl_out;
    logic       active;
`ifdef RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_mode;
    int         m_since;
    int         m_coms;
    int         m_zeros;
    int         m_err;
    logic [7:0] m_win;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_idl;

    serie_paralelo_idl dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .idl_out   (idl_out),
        .active    (active)
`ifdef RX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_SEARCH;
        m_since = 0;
        m_coms  = 0;
        m_zeros = 0;
        m_err   = 0;
        m_win   = 8'h00;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_idl   = 1'b0;
    endtask

    task automatic model_fail();
        m_mode = M_SEARCH;
        if (m_err < 255) m_err++;
    endtask

    // One received bit: a byte completes every 8 bits after the COM that anchored alignment.
    task automatic model_step(input logic b);
        m_win   = {m_win[6:0], b};
        m_valid = 1'b0;
        m_idl   = 1'b0;
        if (m_mode == M_SEARCH) begin
            if (m_win == 8'hBC) begin
                m_since = 0;
                m_coms  = 1;
                m_zeros = 0;
                m_mode  = (LOCK == 1) ? M_LOCKED : M_ALIGN;
            end
        end else begin
            m_since++;
            if (m_since % 8 == 0) begin
                if (m_mode == M_ALIGN) begin
                    if (m_win == 8'hBC) begin
                        m_coms++;
                        if (m_coms == LOCK) m_mode = M_LOCKED;
                    end else begin
                        model_fail();
                    end
                end else begin
                    m_data  = m_win;
                    m_idl   = (m_win == 8'hFC);
                    m_valid = (m_win != 8'hBC) && (m_win != 8'hFC);
                    if (m_win == 8'h00 || m_win == 8'hFF) begin
                        m_zeros++;
                        if (m_zeros == LOSS) begin
                            m_zeros = 0;
                            model_fail();
                        end
                    end else begin
                        m_zeros = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        check("data_out", data_out, m_data);
        check("valid_out", {7'd0, valid_out}, {7'd0, m_valid});
        check("idl_out", {7'd0, idl_out}, {7'd0, m_idl});
        check("active", {7'd0, active}, {7'd0, m_mode == M_LOCKED});
`ifdef RX_ERR_CNT_EN
        check("err_cnt", err_cnt, 8'(m_err));
`endif
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        check_model();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_bytes(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v);
    endtask

    initial begin
        model_reset();
        reset_L = 1'b0;
        data_in = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        check("reset_data", data_out, 8'h00);
        check("reset_active", {7'd0, active}, 8'h00);
        @(negedge clk_32f);
        reset_L = 1'b1;

        // Idle line: nothing may happen
        for (int i = 0; i < 64; i++) send_bit(1'b0);
        check("idle_active", {7'd0, active}, 8'h00);

        // Lock on four COMs, then idles
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        send_bytes(8'hBC, 3);
        check("three_com_not_locked", {7'd0, active}, 8'h00);
        send_byte(8'hBC);
        check("lock_after_4th_com", {7'd0, active}, 8'h01);
        send_byte(8'hFC);
        check("idl_pulse", {7'd0, idl_out}, 8'h01);
        check("idl_no_valid", {7'd0, valid_out}, 8'h00);
        check("idl_data", data_out, 8'hFC);
        send_bit(1'b1);
        check("idl_pulse_one_cycle", {7'd0, idl_out}, 8'h00);
        for (int i = 0; i < 7; i++) send_bit(m_win[7 - (i % 8)] ^ 1'b0 ? 1'b1 : (i < 5));
        send_bytes(8'hFC, 3);

        // Data, silent COM, data
        send_byte(8'h5A);
        check("valid_5a", {7'd0, valid_out}, 8'h01);
        check("data_5a", data_out, 8'h5A);
        send_byte(8'hBC);
        check("com_silent", {7'd0, valid_out}, 8'h00);
        check("com_keeps_lock", {7'd0, active}, 8'h01);
        send_byte(8'h3C);
        check("valid_3c", {7'd0, valid_out}, 8'h01);
        check("data_3c", data_out, 8'h3C);

        // Loss of lock on four 00 bytes; last one still pulses valid
        send_bytes(8'h00, 3);
        check("three_zero_locked", {7'd0, active}, 8'h01);
        send_byte(8'h00);
        check("loss_drops_lock", {7'd0, active}, 8'h00);
        check("loss_last_valid", {7'd0, valid_out}, 8'h01);

        // Alignment broken by a non-COM, then relock
        send_bytes(8'hBC, 2);
        send_byte(8'h12);
        check("align_fail", {7'd0, active}, 8'h00);
        send_bytes(8'hBC, 4);
        check("relock", {7'd0, active}, 8'h01);

        // Loss counter cleared by FC
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hFC);
        send_byte(8'h00);
        check("fc_clears_loss", {7'd0, active}, 8'h01);
        send_byte(8'hFF);
        send_byte(8'hFF);
        check("ff_run_locked", {7'd0, active}, 8'h01);
        send_byte(8'hA5);

        // Asynchronous reset mid-byte while locked
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check("async_active", {7'd0, active}, 8'h00);
        check("async_data", data_out, 8'h00);
        check("async_valid", {7'd0, valid_out}, 8'h00);
        @(posedge clk_32f);
        @(negedge clk_32f);
        reset_L = 1'b1;
        send_bytes(8'hBC, 3);
        check("post_reset_3com", {7'd0, active}, 8'h00);
        send_byte(8'hBC);
        check("post_reset_relock", {7'd0, active}, 8'h01);

        // Random link traffic with bursts, loss runs and bit slips
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1: send_bytes(8'hBC, int'($urandom_range(3, 6)));
                2:    send_byte(8'hFC);
                3:    send_bytes(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, int'($urandom_range(1, 5)));
                4: begin
                    int slips;
                    slips = int'($urandom_range(1, 7));
                    for (int i = 0; i < slips; i++) send_bit(1'($urandom_range(0, 1)));
                end
                default: send_byte(8'($urandom_range(0, 255)));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
